// File: rtl/ftq_queue.sv
// rtl/ftq_queue.sv - fetch target queue between BPU, fetch and the backend branch/commit path
module ftq_queue #(
  parameter int FTQ_SIZE = 16,
  parameter int BRU_NUM  = 2,
  parameter int XLEN     = 64,
  parameter int IW       = $clog2(FTQ_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  // BPU enqueue
  input  logic                i_pred_vld,
  output logic                o_pred_rdy,
  input  logic [XLEN-1:0]     i_pred_startAddr,
  input  logic [XLEN-1:0]     i_pred_nextAddr,
  // in-order issue to fetch
  output logic                o_fetch_vld,
  input  logic                i_fetch_rdy,
  output logic [IW-1:0]       o_fetch_ftqIdx,
  output logic [XLEN-1:0]     o_fetch_startAddr,
  output logic [XLEN-1:0]     o_fetch_nextAddr,
  // backend combinational reads
  input  logic [IW-1:0]       i_read_ftqIdx [BRU_NUM],
  output logic [XLEN-1:0]     o_read_startAddr [BRU_NUM],
  output logic [XLEN-1:0]     o_read_nextAddr [BRU_NUM],
  // branch writeback
  input  logic [BRU_NUM-1:0]  i_branchwb_vld,
  input  logic [IW-1:0]       i_branchwb_ftqIdx [BRU_NUM],
  input  logic [BRU_NUM-1:0]  i_branchwb_mispred,
  input  logic [XLEN-1:0]     i_branchwb_target [BRU_NUM],
  // backend redirect
  input  logic                i_squash_vld,
  input  logic [IW-1:0]       i_squash_ftqIdx,
  input  logic [XLEN-1:0]     i_squash_arch_pc,
  // commit and BPU training
  input  logic                i_commit_ftq_vld,
  input  logic [IW-1:0]       i_commit_ftqIdx,
  output logic                o_bpu_update_vld,
  output logic [XLEN-1:0]     o_bpu_update_startAddr,
  output logic [XLEN-1:0]     o_bpu_update_nextAddr,
  output logic                o_bpu_update_mispred
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PW = IW + 1;

  logic [XLEN-1:0]     start_q [FTQ_SIZE];
  logic [XLEN-1:0]     next_q  [FTQ_SIZE];
  logic [FTQ_SIZE-1:0] mispred_q;

  logic [PW-1:0] head_q, fetch_q, tail_q;
  logic [PW-1:0] head_d, fetch_d, tail_d;
  logic [PW-1:0] count;
  logic [PW-1:0] sq_ptr;
  logic [IW-1:0] head_idx, fetch_idx, tail_idx;
  logic [IW-1:0] sq_dist;
  logic          full, empty, fetch_pending;
  logic          enq_fire, fetch_fire, commit_ok;

  assign head_idx  = head_q[IW-1:0];
  assign fetch_idx = fetch_q[IW-1:0];
  assign tail_idx  = tail_q[IW-1:0];

  assign count         = tail_q - head_q;
  assign full          = (count == PW'(FTQ_SIZE));
  assign empty         = (tail_q == head_q);
  assign fetch_pending = (fetch_q != tail_q);

  // Ready looks only at the current occupancy; a same-cycle commit does not
  // open a slot until the next cycle.
  assign o_pred_rdy = !full;
  assign enq_fire   = i_pred_vld && !full && !i_squash_vld;

  // A redirect in flight hides the fetch head so nothing wrong-path is issued.
  assign o_fetch_vld       = fetch_pending && !i_squash_vld;
  assign fetch_fire        = o_fetch_vld && i_fetch_rdy;
  assign o_fetch_ftqIdx    = fetch_idx;
  assign o_fetch_startAddr = start_q[fetch_idx];
  assign o_fetch_nextAddr  = next_q[fetch_idx];

  // Commits that do not name the live head are dropped.
  assign commit_ok = i_commit_ftq_vld && !empty && (i_commit_ftqIdx == head_idx);

  // The squashing entry becomes the youngest; its distance from head fixes
  // the wrap bit of the rebuilt tail.
  assign sq_dist = i_squash_ftqIdx - head_idx;
  assign sq_ptr  = head_q + {1'b0, sq_dist} + PW'(1);

  // Backend read ports are plain indexed lookups with no validity filtering.
  for (genvar p = 0; p < BRU_NUM; p++) begin : g_read
    assign o_read_startAddr[p] = start_q[i_read_ftqIdx[p]];
    assign o_read_nextAddr[p]  = next_q[i_read_ftqIdx[p]];
  end

  // Next-pointer selection: squash rewinds tail and fetch, commit always advances head.
  always_comb begin
    head_d  = head_q;
    fetch_d = fetch_q;
    tail_d  = tail_q;
    if (commit_ok) begin
      head_d = head_q + PW'(1);
    end
    if (i_squash_vld) begin
      tail_d  = sq_ptr;
      fetch_d = sq_ptr;
    end else begin
      if (enq_fire) begin
        tail_d = tail_q + PW'(1);
      end
      if (fetch_fire) begin
        fetch_d = fetch_q + PW'(1);
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      fetch_q <= '0;
      tail_q  <= '0;
    end else begin
      head_q  <= head_d;
      fetch_q <= fetch_d;
      tail_q  <= tail_d;
    end
  end

  // Entry storage: enqueue, then mispredict writebacks (higher port last so it
  // wins), with a squash suppressing writebacks and patching its own entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      mispred_q <= '0;
    end else begin
      if (enq_fire) begin
        start_q[tail_idx]   <= i_pred_startAddr;
        next_q[tail_idx]    <= i_pred_nextAddr;
        mispred_q[tail_idx] <= 1'b0;
      end
      if (i_squash_vld) begin
        next_q[i_squash_ftqIdx]    <= i_squash_arch_pc;
        mispred_q[i_squash_ftqIdx] <= 1'b1;
      end else begin
        for (int p = 0; p < BRU_NUM; p++) begin
          if (i_branchwb_vld[p] && i_branchwb_mispred[p]) begin
            next_q[i_branchwb_ftqIdx[p]]    <= i_branchwb_target[p];
            mispred_q[i_branchwb_ftqIdx[p]] <= 1'b1;
          end
        end
      end
    end
  end

  // Training record: snapshot of the head entry as it retires, one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_bpu_update_vld       <= 1'b0;
      o_bpu_update_startAddr <= '0;
      o_bpu_update_nextAddr  <= '0;
      o_bpu_update_mispred   <= 1'b0;
    end else begin
      o_bpu_update_vld <= commit_ok;
      if (commit_ok) begin
        o_bpu_update_startAddr <= start_q[head_idx];
        o_bpu_update_nextAddr  <= next_q[head_idx];
        o_bpu_update_mispred   <= mispred_q[head_idx];
      end
    end
  end

  // Backend must only commit the live head of a non-empty queue.
  always_ff @(posedge clk) begin
    if (!rst && i_commit_ftq_vld) begin
      assert (commit_ok);
    end
  end

endmodule

// File: tb/tb_ftq_queue.sv
// tb/tb_ftq_queue.sv - self-checking bench for ftq_queue against a pointer/array reference model
module tb_ftq_queue;
  localparam int N  = 16;
  localparam int B  = 2;
  localparam int XL = 64;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          pred_vld, pred_rdy;
  logic [XL-1:0] pred_start, pred_next;
  logic          fetch_vld, fetch_rdy;
  logic [IW-1:0] fetch_idx;
  logic [XL-1:0] fetch_start, fetch_next;
  logic [IW-1:0] read_idx [B];
  logic [XL-1:0] read_start [B];
  logic [XL-1:0] read_next [B];
  logic [B-1:0]  wb_vld, wb_mis;
  logic [IW-1:0] wb_idx [B];
  logic [XL-1:0] wb_tgt [B];
  logic          sq_vld;
  logic [IW-1:0] sq_idx;
  logic [XL-1:0] sq_pc;
  logic          cm_vld;
  logic [IW-1:0] cm_idx;
  logic          upd_vld, upd_mis;
  logic [XL-1:0] upd_start, upd_next;

  ftq_queue #(.FTQ_SIZE(N), .BRU_NUM(B), .XLEN(XL)) dut (
    .clk(clk), .rst(rst),
    .i_pred_vld(pred_vld), .o_pred_rdy(pred_rdy),
    .i_pred_startAddr(pred_start), .i_pred_nextAddr(pred_next),
    .o_fetch_vld(fetch_vld), .i_fetch_rdy(fetch_rdy), .o_fetch_ftqIdx(fetch_idx),
    .o_fetch_startAddr(fetch_start), .o_fetch_nextAddr(fetch_next),
    .i_read_ftqIdx(read_idx), .o_read_startAddr(read_start), .o_read_nextAddr(read_next),
    .i_branchwb_vld(wb_vld), .i_branchwb_ftqIdx(wb_idx),
    .i_branchwb_mispred(wb_mis), .i_branchwb_target(wb_tgt),
    .i_squash_vld(sq_vld), .i_squash_ftqIdx(sq_idx), .i_squash_arch_pc(sq_pc),
    .i_commit_ftq_vld(cm_vld), .i_commit_ftqIdx(cm_idx),
    .o_bpu_update_vld(upd_vld), .o_bpu_update_startAddr(upd_start),
    .o_bpu_update_nextAddr(upd_next), .o_bpu_update_mispred(upd_mis)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: unbounded sequence numbers, slot = seq % N.
  logic [XL-1:0] m_start [N];
  logic [XL-1:0] m_next [N];
  bit            m_mis [N];
  bit            m_wr [N];
  int            h, f, t;
  bit            e_vld, e_mis;
  logic [XL-1:0] e_start, e_next;

  task automatic clear_inputs();
    pred_vld = 0; pred_start = '0; pred_next = '0; fetch_rdy = 0;
    wb_vld = '0; wb_mis = '0; sq_vld = 0; sq_idx = '0; sq_pc = '0;
    cm_vld = 0; cm_idx = '0;
    for (int p = 0; p < B; p++) begin
      read_idx[p] = '0; wb_idx[p] = '0; wb_tgt[p] = '0;
    end
  endtask

  task automatic model_step();
    bit sq, cok, ff, enq;
    int d;
    if (rst) begin
      h = 0; f = 0; t = 0;
      for (int i = 0; i < N; i++) m_mis[i] = 0;
      e_vld = 0; e_mis = 0; e_start = '0; e_next = '0;
      return;
    end
    sq  = sq_vld;
    cok = cm_vld && (t > h) && (cm_idx == IW'(h % N));
    ff  = (f != t) && !sq && fetch_rdy;
    enq = pred_vld && ((t - h) < N) && !sq;
    e_vld = cok;
    if (cok) begin
      e_start = m_start[h % N]; e_next = m_next[h % N]; e_mis = m_mis[h % N];
    end
    if (enq) begin
      m_start[t % N] = pred_start; m_next[t % N] = pred_next;
      m_mis[t % N] = 0; m_wr[t % N] = 1; t++;
    end
    if (sq) begin
      m_next[sq_idx] = sq_pc; m_mis[sq_idx] = 1;
      d = (int'(sq_idx) - (h % N) + N) % N;
      t = h + d + 1; f = t;
    end else begin
      for (int p = 0; p < B; p++)
        if (wb_vld[p] && wb_mis[p]) begin
          m_next[wb_idx[p]] = wb_tgt[p]; m_mis[wb_idx[p]] = 1;
        end
      if (ff) f++;
    end
    if (cok) h++;
  endtask

  task automatic clk_step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; clear_inputs(); clk_step(); rst = 0; #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pred_rdy !== 1'b1) begin errors++; $display("FAIL reset_pred_rdy got %b want 1", pred_rdy); end
    checks++; if (fetch_vld !== 1'b0) begin errors++; $display("FAIL reset_fetch_vld got %b want 0", fetch_vld); end
    checks++; if (upd_vld !== 1'b0) begin errors++; $display("FAIL reset_upd_vld got %b want 0", upd_vld); end
    checks++; if (upd_start !== '0 || upd_next !== '0 || upd_mis !== 1'b0) begin
      errors++; $display("FAIL reset_upd_data got %h/%h/%b want 0", upd_start, upd_next, upd_mis); end
  endtask

  task automatic test_enqueue_fetch();
    pred_vld = 1; pred_start = 64'h1000; pred_next = 64'h1020; fetch_rdy = 1; #1;
    checks++; if (fetch_vld !== 1'b0) begin errors++; $display("FAIL enq_no_bypass got %b want 0", fetch_vld); end
    clk_step(); pred_vld = 0; #1;
    checks++; if (fetch_vld !== 1'b1) begin errors++; $display("FAIL enq_fetch_vld got %b want 1", fetch_vld); end
    checks++; if (fetch_idx !== 4'd0) begin errors++; $display("FAIL enq_fetch_idx got %0d want 0", fetch_idx); end
    checks++; if (fetch_start !== 64'h1000) begin errors++; $display("FAIL enq_fetch_start got %h want 1000", fetch_start); end
    checks++; if (fetch_next !== 64'h1020) begin errors++; $display("FAIL enq_fetch_next got %h want 1020", fetch_next); end
    clk_step();
    checks++; if (fetch_vld !== 1'b0) begin errors++; $display("FAIL enq_fetch_drained got %b want 0", fetch_vld); end
    fetch_rdy = 0;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < N; i++) begin
      pred_vld = 1; pred_start = 64'h2000 + 64'(i) * 64'h40; pred_next = pred_start + 64'h40; #1;
      checks++; if (pred_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_fill%0d got %b want 1", i, pred_rdy); end
      clk_step();
    end
    pred_vld = 0; #1;
    checks++; if (pred_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_at16 got %b want 0", pred_rdy); end
    pred_vld = 1; pred_start = 64'hdead; pred_next = 64'hbeef; cm_vld = 1; cm_idx = 0; #1;
    checks++; if (pred_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_commit_cycle got %b want 0", pred_rdy); end
    clk_step(); cm_vld = 0; pred_vld = 0; #1;
    checks++; if (pred_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_after_commit got %b want 1", pred_rdy); end
    checks++; if (upd_vld !== 1'b1 || upd_start !== 64'h2000) begin
      errors++; $display("FAIL full_commit_upd got %b/%h want 1/2000", upd_vld, upd_start); end
    pred_vld = 1; pred_start = 64'h3000; pred_next = 64'h3010; clk_step(); pred_vld = 0; #1;
    checks++; if (pred_rdy !== 1'b0) begin errors++; $display("FAIL full_refill got %b want 0", pred_rdy); end
  endtask

  task automatic test_read();
    read_idx[0] = 3; read_idx[1] = 3; #1;
    for (int p = 0; p < B; p++) begin
      checks++; if (read_start[p] !== 64'h20c0) begin errors++; $display("FAIL read_start_p%0d got %h want 20c0", p, read_start[p]); end
      checks++; if (read_next[p] !== 64'h2100) begin errors++; $display("FAIL read_next_p%0d got %h want 2100", p, read_next[p]); end
    end
    read_idx[1] = 0; #1;
    checks++; if (read_start[1] !== 64'h3000) begin errors++; $display("FAIL read_wrapped_slot got %h want 3000", read_start[1]); end
  endtask

  task automatic test_branchwb();
    logic [XL-1:0] want_next [4];
    bit            want_mis [4];
    do_reset(); fetch_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      pred_vld = 1; pred_start = 64'h5000 + 64'(i) * 64'h10; pred_next = pred_start + 64'h10; clk_step();
    end
    pred_vld = 0; clk_step(); clk_step();
    wb_vld = 2'b11; wb_mis = 2'b01;
    wb_idx[0] = 2; wb_tgt[0] = 64'h4000; wb_idx[1] = 1; wb_tgt[1] = 64'h9999; clk_step();
    wb_mis = 2'b11; wb_idx[0] = 3; wb_tgt[0] = 64'ha000; wb_idx[1] = 3; wb_tgt[1] = 64'hb000; clk_step();
    wb_vld = '0; wb_mis = '0;
    want_next[0] = 64'h5010; want_next[1] = 64'h5020; want_next[2] = 64'h4000; want_next[3] = 64'hb000;
    want_mis[0] = 0; want_mis[1] = 0; want_mis[2] = 1; want_mis[3] = 1;
    for (int i = 0; i < 4; i++) begin
      cm_vld = 1; cm_idx = IW'(i); clk_step();
      checks++; if (upd_vld !== 1'b1 || upd_start !== 64'h5000 + 64'(i) * 64'h10) begin
        errors++; $display("FAIL wb_upd_start%0d got %b/%h", i, upd_vld, upd_start); end
      checks++; if (upd_next !== want_next[i] || upd_mis !== want_mis[i]) begin
        errors++; $display("FAIL wb_upd_next%0d got %h/%b want %h/%b", i, upd_next, upd_mis, want_next[i], want_mis[i]); end
    end
    cm_vld = 0; clk_step();
    checks++; if (upd_vld !== 1'b0) begin errors++; $display("FAIL wb_upd_pulse got %b want 0", upd_vld); end
    fetch_rdy = 0;
  endtask

  task automatic test_squash();
    do_reset(); fetch_rdy = 1;
    for (int i = 0; i < 6; i++) begin
      pred_vld = 1; pred_start = 64'h6000 + 64'(i) * 64'h20; pred_next = pred_start + 64'h20; clk_step();
    end
    pred_vld = 0; clk_step();
    checks++; if (fetch_vld !== 1'b0) begin errors++; $display("FAIL sq_all_fetched got %b want 0", fetch_vld); end
    sq_vld = 1; sq_idx = 1; sq_pc = 64'h8000; pred_vld = 1; pred_start = 64'h7777; pred_next = 64'h7788; #1;
    checks++; if (fetch_vld !== 1'b0) begin errors++; $display("FAIL sq_fetch_masked got %b want 0", fetch_vld); end
    clk_step(); sq_vld = 0; pred_vld = 0; read_idx[0] = 1; #1;
    checks++; if (read_next[0] !== 64'h8000) begin errors++; $display("FAIL sq_entry_next got %h want 8000", read_next[0]); end
    checks++; if (fetch_vld !== 1'b0) begin errors++; $display("FAIL sq_enq_dropped got %b want 0", fetch_vld); end
    pred_vld = 1; pred_start = 64'h7000; pred_next = 64'h7040; clk_step(); pred_vld = 0; #1;
    checks++; if (fetch_vld !== 1'b1 || fetch_idx !== 4'd2 || fetch_start !== 64'h7000) begin
      errors++; $display("FAIL sq_refetch got %b/%0d/%h want 1/2/7000", fetch_vld, fetch_idx, fetch_start); end
    cm_vld = 1; cm_idx = 0; clk_step(); cm_idx = 1; clk_step(); cm_vld = 0;
    checks++; if (upd_vld !== 1'b1 || upd_next !== 64'h8000 || upd_mis !== 1'b1) begin
      errors++; $display("FAIL sq_commit_upd got %b/%h/%b want 1/8000/1", upd_vld, upd_next, upd_mis); end
    fetch_rdy = 0;
  endtask

  task automatic test_wrap();
    do_reset(); fetch_rdy = 1;
    for (int c = 0; c < 45; c++) begin
      pred_vld = 1; pred_start = {32'h0, $urandom}; pred_next = {32'h0, $urandom};
      cm_vld = (h < f); cm_idx = IW'(h % N); #1;
      checks++; if (pred_rdy !== ((t - h) < N)) begin errors++; $display("FAIL wrap_pred_rdy c%0d got %b", c, pred_rdy); end
      checks++; if (fetch_vld !== (f != t)) begin errors++; $display("FAIL wrap_fetch_vld c%0d got %b", c, fetch_vld); end
      if (f != t) begin
        checks++; if (fetch_idx !== IW'(f % N) || fetch_start !== m_start[f % N]) begin
          errors++; $display("FAIL wrap_fetch_data c%0d got %0d/%h want %0d/%h", c, fetch_idx, fetch_start, f % N, m_start[f % N]); end
      end
      clk_step();
      checks++; if (upd_vld !== e_vld || (e_vld && upd_start !== e_start)) begin
        errors++; $display("FAIL wrap_upd c%0d got %b/%h want %b/%h", c, upd_vld, upd_start, e_vld, e_start); end
    end
    pred_vld = 0; cm_vld = 0;
    checks++; if (t < 2 * N) begin errors++; $display("FAIL wrap_progress got %0d want >= %0d", t, 2 * N); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      rst = (c == 200);
      pred_vld = $urandom_range(0, 3) != 0;
      pred_start = {$urandom, $urandom}; pred_next = {$urandom, $urandom};
      fetch_rdy = $urandom_range(0, 1);
      for (int p = 0; p < B; p++) read_idx[p] = IW'($urandom);
      if (f > h && $urandom_range(0, 1) == 1) begin cm_vld = 1; cm_idx = IW'(h % N); end
      if (f > h && $urandom_range(0, 15) == 0) begin
        sq_vld = 1; sq_idx = IW'($urandom_range(h, f - 1) % N); sq_pc = {$urandom, $urandom};
      end else if (f > h) begin
        for (int p = 0; p < B; p++) begin
          wb_vld[p] = $urandom_range(0, 1); wb_mis[p] = $urandom_range(0, 1);
          wb_idx[p] = IW'($urandom_range(h, f - 1) % N); wb_tgt[p] = {$urandom, $urandom};
        end
      end
      #1;
      if (!rst) begin
        checks++; if (pred_rdy !== ((t - h) < N)) begin errors++; $display("FAIL rnd_pred_rdy c%0d got %b", c, pred_rdy); end
        checks++; if (fetch_vld !== ((f != t) && !sq_vld)) begin errors++; $display("FAIL rnd_fetch_vld c%0d got %b", c, fetch_vld); end
        if (f != t && !sq_vld) begin
          checks++; if (fetch_idx !== IW'(f % N) || fetch_start !== m_start[f % N] || fetch_next !== m_next[f % N]) begin
            errors++; $display("FAIL rnd_fetch_data c%0d got %0d/%h/%h want %0d/%h/%h", c, fetch_idx, fetch_start, fetch_next, f % N, m_start[f % N], m_next[f % N]); end
        end
        for (int p = 0; p < B; p++)
          if (m_wr[read_idx[p]]) begin
            checks++; if (read_start[p] !== m_start[read_idx[p]] || read_next[p] !== m_next[read_idx[p]]) begin
              errors++; $display("FAIL rnd_read_p%0d c%0d got %h/%h want %h/%h", p, c, read_start[p], read_next[p], m_start[read_idx[p]], m_next[read_idx[p]]); end
          end
      end
      clk_step();
      checks++; if (upd_vld !== e_vld) begin errors++; $display("FAIL rnd_upd_vld c%0d got %b want %b", c, upd_vld, e_vld); end
      if (e_vld) begin
        checks++; if (upd_start !== e_start || upd_next !== e_next || upd_mis !== e_mis) begin
          errors++; $display("FAIL rnd_upd_data c%0d got %h/%h/%b want %h/%h/%b", c, upd_start, upd_next, upd_mis, e_start, e_next, e_mis); end
      end
    end
    rst = 0; clear_inputs();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin m_wr[i] = 0; m_mis[i] = 0; end
    rst = 1; clear_inputs();
    test_reset();
    test_enqueue_fetch();
    test_full();
    test_read();
    test_branchwb();
    test_squash();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
